// File: rtl/arcade_input_mapper_if.sv
// Bus between hps_io-side stimulus and arcade_input_mapper.
// The master drives keyboard/joystick/rotation; the slave returns cabinet controls.
interface arcade_input_mapper_if #(
  parameter int PLAYERS = 2
);
  logic [64:0]            ps2_key;
  logic [16*PLAYERS-1:0]  joy_in;
  logic [1:0]             rot;
  logic [7*PLAYERS-1:0]   ctl_out;
  logic                   kbd_active;

  modport master (
    output ps2_key, joy_in, rot,
    input  ctl_out, kbd_active
  );

  modport slave (
    input  ps2_key, joy_in, rot,
    output ctl_out, kbd_active
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key events and joystick words into per-player {coin,start,fire,U,D,L,R},
// with rotation and a timed coin pulse. Optional autofire enabled by defining AUTOFIRE_EN.
module arcade_input_mapper #(
  parameter int PLAYERS       = 2,
  parameter int COIN_PULSE    = 500000,
  parameter int COIN_ON_START = 1,
  parameter int AUTOFIRE_DIV  = 600000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  arcade_input_mapper_if.slave  bus
);

  localparam int CW = $clog2(COIN_PULSE) + 1;
  localparam logic [CW-1:0] COIN_LAST = CW'(COIN_PULSE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } coin_state_t;

  // Key event decode
  logic       r_tog;
  logic       w_event;
  logic       w_pressed;
  logic       w_ext;
  logic [7:0] w_code;

  // Tracks bit 64 through reset so a stale toggle is never replayed afterwards.
  always_ff @(posedge clk_sys) begin
    r_tog <= bus.ps2_key[64];
  end

  assign w_pressed = (bus.ps2_key[15:8] != 8'hF0);
  assign w_ext     = w_pressed ? (bus.ps2_key[15:8] == 8'hE0) : (bus.ps2_key[23:16] == 8'hE0);
  assign w_code    = bus.ps2_key[7:0];
  assign w_event   = (bus.ps2_key[64] != r_tog) && (bus.ps2_key[63:24] == 40'd0);

  logic r_k_up, r_k_down, r_k_left, r_k_right, r_k_fire;
  logic r_k_start0, r_k_coin0, r_k_start1, r_k_coin1;
  logic r_kbd_active;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_k_up     <= 1'b0;
      r_k_down   <= 1'b0;
      r_k_left   <= 1'b0;
      r_k_right  <= 1'b0;
      r_k_fire   <= 1'b0;
      r_k_start0 <= 1'b0;
      r_k_coin0  <= 1'b0;
      r_k_start1 <= 1'b0;
      r_k_coin1  <= 1'b0;
    end else if (w_event) begin
      if (w_code == 8'h75) r_k_up    <= w_pressed;
      if (w_code == 8'h72) r_k_down  <= w_pressed;
      if (w_code == 8'h6B) r_k_left  <= w_pressed;
      if (w_code == 8'h74) r_k_right <= w_pressed;
      // Space and ctrl share one fire state; whichever event came last decides it.
      if (!w_ext && (w_code == 8'h29 || w_code == 8'h14)) r_k_fire <= w_pressed;
      if (!w_ext && w_code == 8'h05) r_k_start0 <= w_pressed;
      if (!w_ext && w_code == 8'h2E) r_k_coin0  <= w_pressed;
      if (PLAYERS > 1 && !w_ext && w_code == 8'h06) r_k_start1 <= w_pressed;
      if (PLAYERS > 1 && !w_ext && w_code == 8'h36) r_k_coin1  <= w_pressed;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_kbd_active <= 1'b0;
    end else begin
      r_kbd_active <= r_k_up | r_k_down | r_k_left | r_k_right | r_k_fire |
                      r_k_start0 | r_k_coin0 | r_k_start1 | r_k_coin1;
    end
  end

  assign bus.kbd_active = r_kbd_active;

`ifdef AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_DIV) + 1;
  logic [AW-1:0] r_af_cnt;
  logic          r_af_phase;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (r_af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt   <= r_af_cnt + 1'b1;
    end
  end
`endif

  logic [6:0] w_ctl [PLAYERS];

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
    logic [6:0]    w_kbd;
    logic [6:0]    w_raw;
    logic          w_fire;
    logic          w_up, w_down, w_left, w_right;
    logic          w_req;
    logic          w_unused_joy;
    logic [5:0]    r_ctl;
    logic          r_coin;
    logic          r_req_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    coin_state_t   r_state;
    coin_state_t   w_state_next;

    if (gi == 0) begin : g_kbd0
      assign w_kbd = {r_k_coin0, r_k_start0, r_k_fire, r_k_up, r_k_down, r_k_left, r_k_right};
    end else if (gi == 1) begin : g_kbd1
      assign w_kbd = {r_k_coin1, r_k_start1, 5'b0};
    end else begin : g_kbdn
      assign w_kbd = 7'b0;
    end

    assign w_raw = bus.joy_in[16*gi +: 7] | w_kbd;

`ifdef AUTOFIRE_EN
    assign w_fire       = w_raw[4] | (bus.joy_in[16*gi+8] & r_af_phase);
    assign w_unused_joy = ^{bus.joy_in[16*gi+7], bus.joy_in[16*gi+9 +: 7]};
`else
    assign w_fire       = w_raw[4];
    assign w_unused_joy = ^bus.joy_in[16*gi+7 +: 9];
`endif

    // w_raw[3:0] = {U,D,L,R}
    always_comb begin
      {w_up, w_down, w_left, w_right} = w_raw[3:0];
      case (bus.rot)
        2'd1:    {w_up, w_down, w_left, w_right} = {w_raw[1], w_raw[0], w_raw[2], w_raw[3]};
        2'd2:    {w_up, w_down, w_left, w_right} = {w_raw[2], w_raw[3], w_raw[0], w_raw[1]};
        2'd3:    {w_up, w_down, w_left, w_right} = {w_raw[0], w_raw[1], w_raw[3], w_raw[2]};
        default: ;
      endcase
    end

    assign w_req = w_raw[6] | ((COIN_ON_START != 0) && w_raw[5]);

    // r_armed stays low after reset until the request has been seen released.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        S_IDLE: begin
          if (w_req && !r_req_prev && r_armed) begin
            w_state_next = S_PULSE;
            w_cnt_next   = '0;
          end
        end
        S_PULSE: begin
          if (r_cnt == COIN_LAST) begin
            w_state_next = S_GAP;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == COIN_LAST) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_coin     <= 1'b0;
        r_req_prev <= 1'b0;
        r_armed    <= 1'b0;
        r_ctl      <= '0;
      end else begin
        r_state    <= w_state_next;
        r_cnt      <= w_cnt_next;
        r_coin     <= (w_state_next == S_PULSE);
        r_req_prev <= w_req;
        r_armed    <= r_armed | ~w_req;
        r_ctl      <= {w_raw[5], w_fire, w_up, w_down, w_left, w_right};
      end
    end

    assign w_ctl[gi] = {r_coin, r_ctl};
  end

  always_comb begin
    bus.ctl_out = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      bus.ctl_out[7*p +: 7] = w_ctl[p];
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomised and directed checks of arcade_input_mapper against a cycle-level reference model.
// Define AUTOFIRE_EN for both bench and RTL to exercise the autofire path.
module tb_arcade_input_mapper;

  localparam int P   = 2;
  localparam int CP  = 4;
  localparam int COS = 1;
  localparam int AFD = 3;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if #(.PLAYERS(P)) bus ();

  arcade_input_mapper #(
    .PLAYERS(P), .COIN_PULSE(CP), .COIN_ON_START(COS), .AUTOFIRE_DIV(AFD)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  logic [64:0] ps2 = '0;
  logic [31:0] joy = '0;
  logic [1:0]  rot = '0;
  assign bus.ps2_key = ps2;
  assign bus.joy_in  = joy;
  assign bus.rot     = rot;

  // Model state: key index 0 up,1 down,2 left,3 right,4 fire,5 start0,6 coin0,7 start1,8 coin1
  bit          k_state [9];
  bit          m_tog;
  bit          m_prev  [P];
  bit          m_armed [P];
  int          m_left  [P];
  int          m_n;
  logic [13:0] exp_ctl = '0;
  logic        exp_kbd = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] codes [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14,
                             8'h05, 8'h2E, 8'h06, 8'h36, 8'h1C, 8'h0D};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [64:0] mk_evt(logic tog, logic [7:0] code, bit ext, bit rel);
    logic [64:0] w;
    w = '0;
    w[64]  = tog;
    w[7:0] = code;
    if (rel) begin
      w[15:8] = 8'hF0;
      if (ext) w[23:16] = 8'hE0;
    end else if (ext) begin
      w[15:8] = 8'hE0;
    end
    return w;
  endfunction

  function automatic int key_index(logic [64:0] w);
    bit rel, ext;
    if (w[63:24] != 40'd0) return -1;
    rel = (w[15:8] == 8'hF0);
    ext = rel ? (w[23:16] == 8'hE0) : (w[15:8] == 8'hE0);
    case (w[7:0])
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: ;
    endcase
    if (ext) return -1;
    case (w[7:0])
      8'h29, 8'h14: return 4;
      8'h05: return 5;
      8'h2E: return 6;
      8'h06: return 7;
      8'h36: return 8;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) k_state[i] = 1'b0;
    for (int p = 0; p < P; p++) begin
      m_prev[p] = 1'b0; m_armed[p] = 1'b0; m_left[p] = 0;
    end
    m_n = 0;
    exp_ctl = '0;
    exp_kbd = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [6:0] raw;
    logic u, d, l, r, f;
    bit req, any;
    int idx;
    if (reset) begin
      model_clear();
      m_tog = ps2[64];
      return;
    end
    for (int p = 0; p < P; p++) begin
      raw = joy[16*p +: 7];
      if (p == 0) raw |= {k_state[6], k_state[5], k_state[4], k_state[0], k_state[1], k_state[2], k_state[3]};
      if (p == 1) raw |= {k_state[8], k_state[7], 5'b0};
      f = raw[4];
`ifdef AUTOFIRE_EN
      if (joy[16*p+8] && ((m_n / AFD) % 2 == 1)) f = 1'b1;
`endif
      case (rot)
        2'd0: {u, d, l, r} = {raw[3], raw[2], raw[1], raw[0]};
        2'd1: {u, d, l, r} = {raw[1], raw[0], raw[2], raw[3]};
        2'd2: {u, d, l, r} = {raw[2], raw[3], raw[0], raw[1]};
        default: {u, d, l, r} = {raw[0], raw[1], raw[3], raw[2]};
      endcase
      req = raw[6] | ((COS != 0) && raw[5]);
      if (m_left[p] > 0) m_left[p]--;
      else if (req && !m_prev[p] && m_armed[p]) m_left[p] = 2 * CP;
      if (!req) m_armed[p] = 1'b1;
      m_prev[p] = req;
      exp_ctl[7*p +: 7] = {(m_left[p] > CP), raw[5], f, u, d, l, r};
    end
    any = 1'b0;
    for (int i = 0; i < 9; i++) any |= k_state[i];
    exp_kbd = any;
    if (ps2[64] != m_tog) begin
      idx = key_index(ps2);
      if (idx >= 0) k_state[idx] = (ps2[15:8] != 8'hF0);
    end
    m_tog = ps2[64];
    m_n++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    chk("ctl_out", 32'(bus.ctl_out), 32'(exp_ctl));
    chk("kbd_active", 32'(bus.kbd_active), 32'(exp_kbd));
    $display("cyc rst=%0b ps2=%h joy=%h rot=%0d ctl=%h kbd=%0b", reset, ps2[23:0], joy, rot,
             bus.ctl_out, bus.kbd_active);
  endtask

  task automatic rand_steps(int n, bit rnd_joy);
    logic [64:0] w;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(2) == 0) begin
        w = mk_evt(~ps2[64], codes[$urandom_range(11)], 1'($urandom_range(1)), 1'($urandom_range(1)));
        if ($urandom_range(7) == 0) w[63:24] = {32'($urandom), 8'h01};
        ps2 = w;
      end
      if (rnd_joy && $urandom_range(3) == 0) joy = $urandom;
      if ($urandom_range(7) == 0) rot = 2'($urandom_range(3));
      step();
    end
  endtask

  task automatic release_keys();
    for (int i = 0; i < 10; i++) begin
      ps2 = mk_evt(~ps2[64], codes[i], 1'b0, 1'b1);
      step();
    end
  endtask

  int coin_cnt;
  logic [3:0] rot_exp [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};

  initial begin
    model_clear();
    m_tog = 1'b0;

    // Reset held with random inputs: everything stays cleared.
    for (int i = 0; i < 6; i++) begin
      joy = $urandom;
      ps2 = mk_evt(~ps2[64], codes[$urandom_range(11)], 1'b0, 1'b0);
      step();
    end
    reset = 1'b0;
    rand_steps(40, 1'b1);

    // Up arrow press/release, two-cycle keyboard latency.
    joy = '0; rot = 2'd0;
    release_keys();
    step(); step();
    chk("kbd_idle", 32'(bus.kbd_active), 32'd0);
    ps2 = mk_evt(~ps2[64], 8'h75, 1'b0, 1'b0);
    step();
    chk("up_1cyc", 32'(bus.ctl_out[3]), 32'd0);
    step();
    chk("up_2cyc", 32'(bus.ctl_out[3]), 32'd1);
    chk("kbd_on", 32'(bus.kbd_active), 32'd1);
    ps2 = mk_evt(~ps2[64], 8'h75, 1'b0, 1'b1);
    step(); step();
    chk("up_rel", 32'(bus.ctl_out[3]), 32'd0);
    chk("kbd_off", 32'(bus.kbd_active), 32'd0);

    // Joystick U held through every rotation.
    joy = 32'h0000_0008;
    for (int rr = 0; rr < 4; rr++) begin
      rot = 2'(rr);
      step();
      chk("rot_dir", 32'(bus.ctl_out[3:0]), 32'(rot_exp[rr]));
    end
    rot = 2'd0;

    // P1 coin held 20 cycles with a re-press in the gap: one 4-cycle pulse.
    joy = '0;
    for (int i = 0; i < 12; i++) step();
    coin_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      joy = (i == 6) ? 32'h0 : 32'h0040_0000;
      step();
      if (bus.ctl_out[13]) coin_cnt++;
    end
    chk("p1_coin_len", 32'(coin_cnt), 32'd4);

    // F1 start with coin-on-start, reset mid pulse, no pulse afterwards.
    joy = '0;
    for (int i = 0; i < 12; i++) step();
    ps2 = mk_evt(~ps2[64], 8'h05, 1'b0, 1'b0);
    step(); step();
    chk("f1_start", 32'(bus.ctl_out[5]), 32'd1);
    chk("f1_coin", 32'(bus.ctl_out[6]), 32'd1);
    step();
    #3 reset = 1'b1;
    #1;
    chk("async_rst", 32'(bus.ctl_out), 32'd0);
    model_clear();
    step(); step();
    reset = 1'b0;
    coin_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.ctl_out[6]) coin_cnt++;
    end
    chk("no_coin_post_rst", 32'(coin_cnt), 32'd0);

    // Autofire request on P0.
    joy = 32'h0000_0100;
    for (int i = 0; i < 12; i++) begin
      step();
`ifndef AUTOFIRE_EN
      chk("af_off_fire", 32'(bus.ctl_out[4]), 32'd0);
`endif
    end

    rand_steps(300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
